req_encoder42: RTL and testbench

REQ_ENCODER42 -- requirements
Module: req_encoder42

---
 rtl/req_encoder42.sv | 181 ++++++++++++++++++
 tb/tb_req_encoder42.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/req_encoder42.sv
// -----------------------------------------------------------------------------
// req_encoder42
//
// Purpose:
//   Captures four request lines into a pending register and hands out one
//   granted line index at a time over a valid/ready handshake. Each request
//   that is seen is granted exactly once. A request that arrives while the
//   consumer is stalled is kept until it can be granted.
//
//   Optional feature macro: REQ_ENCODER42_ROUND_ROBIN_EN
//     defined   -> rotating priority. The search starts one position after
//                  the last granted index and wraps 3 -> 0.
//     undefined -> fixed priority I3 > I2 > I1 > I0. No pointer is built.
//
// Ports:
//   clk    in   1  rising-edge clock for all state
//   rst_n  in   1  synchronous active-low reset
//   req    in   4  request lines; req[i] is line Ii, sampled every edge
//   ready  in   1  consumer accepts code when valid & ready at an edge
//   code   out  2  binary index of the granted line
//   valid  out  1  code holds a granted index
//   multi  out  1  another line was still pending when code was loaded
//   pend   out  4  pending-request register
//
// States:
//   state | meaning
//   IDLE  | nothing offered, valid=0; loads a grant as soon as any
//         | candidate exists
//   HOLD  | code/valid/multi offered and held stable until ready
// -----------------------------------------------------------------------------
module req_encoder42 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ready,
    output logic [1:0] code,
    output logic       valid,
    output logic       multi,
    output logic [3:0] pend
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;

    logic [3:0] cand;
    logic [3:0] held_onehot;
    logic [3:0] sel_set;
    logic [1:0] sel_idx;
    logic       sel_multi;
    logic       load;
    logic [3:0] grant_onehot;
    logic [3:0] pend_next;

`ifdef REQ_ENCODER42_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;
    logic       rr_found;
    logic [1:0] rr_idx;
`endif

    // Lines that are pending now plus lines requested on this edge.
    assign cand = pend | req;

    // One-hot of the index currently offered. The bit of a held index was
    // already cleared from pend when it was loaded. If the same line is
    // requested again while it is held, that is a new request. It is not
    // a second grant of the offered one, so it is kept out of the next
    // back-to-back selection.
    assign held_onehot = 4'b0001 << code;

    // Set of lines that the selector picks from on this edge. When nothing
    // may be loaded, the set is empty, so 'load' is just "set is non-empty".
    always_comb begin
        sel_set = 4'b0000;
        case (state)
            IDLE: sel_set = cand;
            HOLD: begin
                if (ready) begin
                    sel_set = cand & ~held_onehot;
                end
            end
            default: sel_set = 4'b0000;
        endcase
    end

    assign load = |sel_set;

    // More than one bit set means another line is still waiting
    // behind the one that gets selected.
    assign sel_multi = |(sel_set & (sel_set - 4'd1));

`ifdef REQ_ENCODER42_ROUND_ROBIN_EN
    // Rotating search: (rr_ptr+1), (rr_ptr+2), (rr_ptr+3), then rr_ptr
    // itself. The 2-bit sum wraps 3 -> 0 on its own.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = 2'b00;
        sel_idx  = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            rr_idx = rr_ptr + 2'(k);
            if (!rr_found && sel_set[rr_idx]) begin
                sel_idx  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end
`else
    // Fixed priority, highest index wins.
    always_comb begin
        sel_idx = 2'b00;
        if (sel_set[3]) begin
            sel_idx = 2'd3;
        end else if (sel_set[2]) begin
            sel_idx = 2'd2;
        end else if (sel_set[1]) begin
            sel_idx = 2'd1;
        end else begin
            sel_idx = 2'd0;
        end
    end
`endif

    assign grant_onehot = load ? (4'b0001 << sel_idx) : 4'b0000;

    // A req bit that is high on the same edge that grants it is absorbed
    // by the grant. If that req is held, it sets pend again on the next
    // edge.
    assign pend_next = cand & ~grant_onehot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            code  <= 2'b00;
            valid <= 1'b0;
            multi <= 1'b0;
            pend  <= 4'b0000;
`ifdef REQ_ENCODER42_ROUND_ROBIN_EN
            rr_ptr <= 2'b11;
`endif
        end else begin
            pend <= pend_next;
            case (state)
                IDLE: begin
                    if (load) begin
                        code  <= sel_idx;
                        multi <= sel_multi;
                        valid <= 1'b1;
                        state <= HOLD;
`ifdef REQ_ENCODER42_ROUND_ROBIN_EN
                        rr_ptr <= sel_idx;
`endif
                    end
                end
                HOLD: begin
                    if (ready) begin
                        if (load) begin
                            code  <= sel_idx;
                            multi <= sel_multi;
                            valid <= 1'b1;
                            state <= HOLD;
`ifdef REQ_ENCODER42_ROUND_ROBIN_EN
                            rr_ptr <= sel_idx;
`endif
                        end else begin
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_encoder42.sv
module tb_req_encoder42;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       ready = 1'b0;
    logic [1:0] code;
    logic       valid;
    logic       multi;
    logic [3:0] pend;

    always #5 clk = ~clk;

    req_encoder42 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ready (ready),
        .code  (code),
        .valid (valid),
        .multi (multi),
        .pend  (pend)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one pending flag per line and one offered grant.
    int m_valid = 0;
    int m_code  = 0;
    int m_multi = 0;
    int m_pend  = 0;
    int m_ptr   = 3;

    function automatic int pick(input int set);
        int r;
        r = 0;
`ifdef REQ_ENCODER42_ROUND_ROBIN_EN
        for (int k = 4; k >= 1; k--) begin
            if (((set >> ((m_ptr + k) % 4)) & 1) == 1) r = (m_ptr + k) % 4;
        end
`else
        for (int i = 0; i < 4; i++) begin
            if (((set >> i) & 1) == 1) r = i;
        end
`endif
        return r;
    endfunction

    task automatic model_step(input bit r, input bit [3:0] q, input bit rd);
        int cand;
        int set;
        int g;
        if (!r) begin
            m_valid = 0; m_code = 0; m_multi = 0; m_pend = 0; m_ptr = 3;
            return;
        end
        cand = m_pend | int'(q);
        set = 0;
        if (m_valid == 0) set = cand;
        else if (rd) set = cand & ~(1 << m_code);
        if (set != 0) begin
            g = pick(set);
            m_multi = ($countones(set) > 1) ? 1 : 0;
            m_code = g;
            m_valid = 1;
            m_ptr = g;
            m_pend = cand & ~(1 << g);
        end else begin
            if (m_valid == 1 && rd) m_valid = 0;
            m_pend = cand;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit r, input bit [3:0] q, input bit rd);
        rst_n = r;
        req   = q;
        ready = rd;
        model_step(r, q, rd);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit       rst;
        bit [3:0] req;
        bit       rdy;
        int       code;
        bit       valid;
        bit       multi;
        bit [3:0] pend;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    function automatic vec_t v(input bit rs, input bit [3:0] q, input bit rd,
                               input int c, input bit vl, input bit m, input bit [3:0] p);
        vec_t x;
        x.rst = rs; x.req = q; x.rdy = rd; x.code = c; x.valid = vl; x.multi = m; x.pend = p;
        return x;
    endfunction

    initial begin
        // reset, req ignored during reset
        tbl[0]  = v(0, 4'b0000, 0, 0, 0, 0, 4'b0000);
        tbl[1]  = v(0, 4'b1111, 1, 0, 0, 0, 4'b0000);
        // isolated pulse, one-edge latency
        tbl[2]  = v(1, 4'b0100, 1, 2, 1, 0, 4'b0000);
        tbl[3]  = v(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
`ifdef REQ_ENCODER42_ROUND_ROBIN_EN
        // last grant 2 -> search starts at 3
        tbl[4]  = v(1, 4'b1111, 1, 3, 1, 1, 4'b0111);
        tbl[5]  = v(1, 4'b0000, 1, 0, 1, 1, 4'b0110);
        tbl[6]  = v(1, 4'b0000, 1, 1, 1, 1, 4'b0100);
        tbl[7]  = v(1, 4'b0000, 1, 2, 1, 0, 4'b0000);
        tbl[8]  = v(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
        tbl[9]  = v(0, 4'b0000, 1, 0, 0, 0, 4'b0000);
        tbl[10] = v(1, 4'b1111, 1, 0, 1, 1, 4'b1110);
        tbl[11] = v(1, 4'b0000, 1, 1, 1, 1, 4'b1100);
        tbl[12] = v(1, 4'b0000, 1, 2, 1, 1, 4'b1000);
        tbl[13] = v(1, 4'b0000, 1, 3, 1, 0, 4'b0000);
`else
        tbl[4]  = v(1, 4'b1111, 1, 3, 1, 1, 4'b0111);
        tbl[5]  = v(1, 4'b0000, 1, 2, 1, 1, 4'b0011);
        tbl[6]  = v(1, 4'b0000, 1, 1, 1, 1, 4'b0001);
        tbl[7]  = v(1, 4'b0000, 1, 0, 1, 0, 4'b0000);
        tbl[8]  = v(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
        tbl[9]  = v(0, 4'b0000, 1, 0, 0, 0, 4'b0000);
        tbl[10] = v(1, 4'b1111, 1, 3, 1, 1, 4'b0111);
        tbl[11] = v(1, 4'b0000, 1, 2, 1, 1, 4'b0011);
        tbl[12] = v(1, 4'b0000, 1, 1, 1, 1, 4'b0001);
        tbl[13] = v(1, 4'b0000, 1, 0, 1, 0, 4'b0000);
`endif
        tbl[14] = v(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
        // stall with code=3, line 1 accumulates
        tbl[15] = v(1, 4'b1000, 0, 3, 1, 0, 4'b0000);
        for (int i = 16; i <= 20; i++) tbl[i] = v(1, 4'b0010, 0, 3, 1, 0, 4'b0010);
        tbl[21] = v(1, 4'b0000, 1, 1, 1, 0, 4'b0000);
        tbl[22] = v(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
        // reset during HOLD with pend=0110
        tbl[23] = v(0, 4'b0000, 0, 0, 0, 0, 4'b0000);
`ifdef REQ_ENCODER42_ROUND_ROBIN_EN
        tbl[24] = v(1, 4'b0111, 0, 0, 1, 1, 4'b0110);
`else
        tbl[24] = v(1, 4'b1110, 0, 3, 1, 1, 4'b0110);
`endif
        tbl[25] = v(0, 4'b0000, 1, 0, 0, 0, 4'b0000);
        tbl[26] = v(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
        tbl[27] = v(1, 4'b0000, 1, 0, 0, 0, 4'b0000);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].rst, tbl[i].req, tbl[i].rdy);
            check($sformatf("vec%0d valid", i), int'(valid), int'(tbl[i].valid));
            check($sformatf("vec%0d pend", i), int'(pend), int'(tbl[i].pend));
            if (tbl[i].valid || !tbl[i].rst) begin
                check($sformatf("vec%0d code", i), int'(code), tbl[i].code);
                check($sformatf("vec%0d multi", i), int'(multi), int'(tbl[i].multi));
            end
        end

        // req[0] held with ready=1: grant every other cycle
        apply(0, 4'b0000, 1);
        for (int k = 0; k < 6; k++) begin
            apply(1, 4'b0001, 1);
            check($sformatf("held0 valid%0d", k), int'(valid), (k % 2 == 0) ? 1 : 0);
            check($sformatf("held0 pend%0d", k), int'(pend), (k % 2 == 0) ? 0 : 1);
            if (k % 2 == 0) check($sformatf("held0 code%0d", k), int'(code), 0);
        end

`ifdef REQ_ENCODER42_ROUND_ROBIN_EN
        // after a grant of 1, line 0 goes before line 1
        apply(0, 4'b0000, 1);
        apply(1, 4'b0010, 1);
        check("rr g1 code", int'(code), 1);
        apply(1, 4'b0000, 1);
        check("rr idle valid", int'(valid), 0);
        apply(1, 4'b0011, 1);
        check("rr first code", int'(code), 0);
        check("rr first multi", int'(multi), 1);
        apply(1, 4'b0000, 1);
        check("rr second code", int'(code), 1);
        check("rr second valid", int'(valid), 1);
`endif

        // randomized run against the model
        apply(0, 4'b0000, 0);
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit [3:0] q;
            bit rd;
            r  = ($urandom_range(0, 49) != 0);
            q  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 2) != 0);
            apply(r, q, rd);
            check($sformatf("rnd%0d valid", i), int'(valid), m_valid);
            check($sformatf("rnd%0d pend", i), int'(pend), m_pend);
            if (m_valid == 1) begin
                check($sformatf("rnd%0d code", i), int'(code), m_code);
                check($sformatf("rnd%0d multi", i), int'(multi), m_multi);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
